dds_sweep_ctrl: RTL and testbench

- Frequency-sweep scheduler for the DDS phase-accumulator/waveform-ROM datapath.
- Steps the output frequency from a start value to a stop value, holding each value for a programmed dwell time.
- Supports a single sweep or a continuous triangle sweep.
- Drives the accumulator increment (phase_inc) and the display frequency (freq_out). Sits between the key/config logic and the phase accumulator.

---
 rtl/dds_sweep_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep scheduler for the DDS phase-accumulator / waveform-ROM path.
// Steps freq_out from a start value to a stop value, holding each value for a
// programmed dwell time, either once (mode 0) or as a continuous triangle
// (mode 1). phase_inc is registered alongside freq_out so the accumulator and
// the display always agree.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   cfg_we     : configuration write strobe
//   cfg_addr   : 0 = f_start, 1 = f_stop, 2 = f_step, 3 = dwell
//   cfg_wdata  : write data (frequency registers use the low FREQ_W bits)
//   start      : level-sampled sweep request (ignored while busy)
//   stop       : abort the running sweep
//   pause      : freeze the sweep while high
//   mode       : 0 = single sweep, 1 = continuous triangle (sampled at start)
//   freq_out   : current frequency in Hz
//   phase_inc  : accumulator increment, freq_out * INC_SCALE
//   busy       : sweep active, including while paused
//   dir        : 0 = heading toward f_stop, 1 = heading toward f_start
//   sweep_tick : one-cycle pulse whenever freq_out changes
//   done       : one-cycle pulse when a single sweep completes
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int unsigned FREQ_W    = 16,
  parameter int unsigned DWELL_W   = 24,
  parameter int unsigned INC_SCALE = 2,
  parameter int unsigned F_MIN     = 50,
  parameter int unsigned F_MAX     = 25000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [DWELL_W-1:0] cfg_wdata,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  output logic [FREQ_W-1:0]  freq_out,
  output logic [FREQ_W+1:0]  phase_inc,
  output logic               busy,
  output logic               dir,
  output logic               sweep_tick,
  output logic               done
);

  localparam logic [FREQ_W-1:0]  FMIN_V  = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0]  FMAX_V  = FREQ_W'(F_MAX);
  localparam logic [FREQ_W-1:0]  ONE_F   = FREQ_W'(1);
  localparam logic [DWELL_W-1:0] ONE_D   = DWELL_W'(1);
  localparam logic [FREQ_W+1:0]  SCALE_V = (FREQ_W+2)'(INC_SCALE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_e;

  state_e              state_q, state_d;

  // Programmable configuration registers.
  logic [FREQ_W-1:0]   f_start_q, f_start_d;
  logic [FREQ_W-1:0]   f_stop_q,  f_stop_d;
  logic [FREQ_W-1:0]   f_step_q,  f_step_d;
  logic [DWELL_W-1:0]  dwell_q,   dwell_d;

  // Snapshot taken at start; the running sweep only ever looks at these.
  logic [FREQ_W-1:0]   s_start_q, s_start_d;
  logic [FREQ_W-1:0]   s_stop_q,  s_stop_d;
  logic [FREQ_W-1:0]   s_step_q,  s_step_d;
  logic [DWELL_W-1:0]  s_dwell_q, s_dwell_d;
  logic                s_mode_q,  s_mode_d;

  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [FREQ_W+1:0]   inc_q,  inc_d;
  logic [DWELL_W-1:0]  cnt_q,  cnt_d;
  logic                busy_q, busy_d;
  logic                dir_q,  dir_d;
  logic                tick_q, tick_d;
  logic                done_q, done_d;

  // Step datapath signals.
  logic [FREQ_W-1:0]   tgt_cur;
  logic                at_target;
  logic                dir_next;
  logic [FREQ_W-1:0]   tgt_next;
  logic [FREQ_W:0]     sum_w;
  logic [FREQ_W:0]     diff_w;
  logic [FREQ_W-1:0]   freq_next;

  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f);
    if (f < FMIN_V)      return FMIN_V;
    else if (f > FMAX_V) return FMAX_V;
    else                 return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Step computation. At the target in triangle mode the direction flips first
  // and the step is taken toward the new target in the same cycle. Sum and
  // difference are one bit wider so wrap-around is caught as overshoot.
  // ---------------------------------------------------------------------------
  always_comb begin
    tgt_cur   = dir_q ? s_start_q : s_stop_q;
    at_target = (freq_q == tgt_cur);
    dir_next  = (at_target && s_mode_q) ? ~dir_q : dir_q;
    tgt_next  = dir_next ? s_start_q : s_stop_q;
    sum_w     = {1'b0, freq_q} + {1'b0, s_step_q};
    diff_w    = {1'b0, freq_q} - {1'b0, s_step_q};

    if (freq_q == tgt_next) begin
      freq_next = freq_q;
    end else if (tgt_next > freq_q) begin
      freq_next = (sum_w > {1'b0, tgt_next}) ? tgt_next : sum_w[FREQ_W-1:0];
    end else begin
      freq_next = (diff_w[FREQ_W] || (diff_w[FREQ_W-1:0] < tgt_next))
                  ? tgt_next : diff_w[FREQ_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and register update logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    f_step_d  = f_step_q;
    dwell_d   = dwell_q;
    s_start_d = s_start_q;
    s_stop_d  = s_stop_q;
    s_step_d  = s_step_q;
    s_dwell_d = s_dwell_q;
    s_mode_d  = s_mode_q;
    freq_d    = freq_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    // Configuration writes are accepted in any state.
    if (cfg_we) begin
      unique case (cfg_addr)
        2'd0: f_start_d = clamp_freq(cfg_wdata[FREQ_W-1:0]);
        2'd1: f_stop_d  = clamp_freq(cfg_wdata[FREQ_W-1:0]);
        2'd2: f_step_d  = (cfg_wdata[FREQ_W-1:0] == '0) ? ONE_F : cfg_wdata[FREQ_W-1:0];
        2'd3: dwell_d   = (cfg_wdata == '0) ? ONE_D : cfg_wdata;
        default: ;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          s_start_d = f_start_q;
          s_stop_d  = f_stop_q;
          s_step_d  = f_step_q;
          s_dwell_d = dwell_q;
          s_mode_d  = mode;
          freq_d    = f_start_q;
          cnt_d     = dwell_q - ONE_D;
          busy_d    = 1'b1;
          dir_d     = 1'b0;
          state_d   = ST_RUN;
        end
      end

      // A PAUSE cycle with pause low counts like a RUN cycle, so the hold time
      // is extended by exactly the number of cycles pause was high.
      ST_RUN, ST_PAUSE: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_D;
          end else if (at_target && !s_mode_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d  = s_dwell_q - ONE_D;
            dir_d  = dir_next;
            freq_d = freq_next;
            tick_d = (freq_next != freq_q);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    inc_d = (FREQ_W+2)'(freq_d) * SCALE_V;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  // Every register here is a plain flop with a defined reset value; there is
  // no memory array that would need to be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      f_start_q <= FMIN_V;
      f_stop_q  <= FMAX_V;
      f_step_q  <= ONE_F;
      dwell_q   <= ONE_D;
      s_start_q <= FMIN_V;
      s_stop_q  <= FMAX_V;
      s_step_q  <= ONE_F;
      s_dwell_q <= ONE_D;
      s_mode_q  <= 1'b0;
      freq_q    <= FMIN_V;
      inc_q     <= (FREQ_W+2)'(FMIN_V) * SCALE_V;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      f_step_q  <= f_step_d;
      dwell_q   <= dwell_d;
      s_start_q <= s_start_d;
      s_stop_q  <= s_stop_d;
      s_step_q  <= s_step_d;
      s_dwell_q <= s_dwell_d;
      s_mode_q  <= s_mode_d;
      freq_q    <= freq_d;
      inc_q     <= inc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign freq_out   = freq_q;
  assign phase_inc  = inc_q;
  assign busy       = busy_q;
  assign dir        = dir_q;
  assign sweep_tick = tick_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed bench for dds_sweep_ctrl. Each step pushes the per-cycle expected
// outputs (frequency, increment, busy, dir, tick, done) onto a scoreboard
// queue; the checker pops one entry per clock, sampling on the falling edge.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

  localparam int FREQ_W  = 16;
  localparam int DWELL_W = 24;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W+1:0] inc;
    logic              busy;
    logic              dir;
    logic              tick;
    logic              done;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [DWELL_W-1:0] cfg_wdata;
  logic               start, stop, pause, mode;
  logic [FREQ_W-1:0]  freq_out;
  logic [FREQ_W+1:0]  phase_inc;
  logic               busy, dir, sweep_tick, done;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mode       (mode),
    .freq_out   (freq_out),
    .phase_inc  (phase_inc),
    .busy       (busy),
    .dir        (dir),
    .sweep_tick (sweep_tick),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Busy cycles: value f held n cycles, tick on the first cycle if tk.
  task automatic push_hold(input int f, input bit d, input int n, input bit tk);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.freq = FREQ_W'(f);
      e.inc  = (FREQ_W+2)'(f * 2);
      e.busy = 1'b1;
      e.dir  = d;
      e.tick = tk && (i == 0);
      e.done = 1'b0;
      q.push_back(e);
    end
  endtask

  // Idle cycle, optionally the done pulse.
  task automatic push_idle(input int f, input bit d, input bit dn);
    exp_t e;
    e.freq = FREQ_W'(f);
    e.inc  = (FREQ_W+2)'(f * 2);
    e.busy = 1'b0;
    e.dir  = d;
    e.tick = 1'b0;
    e.done = dn;
    q.push_back(e);
  endtask

  // Advance n clocks; strobes set before the call last exactly one edge.
  task automatic run_check(input int n, input string tag);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start  = 1'b0;
      stop   = 1'b0;
      cfg_we = 1'b0;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty at step %0d", tag, i);
      end else begin
        e = q.pop_front();
        got.freq = freq_out;
        got.inc  = phase_inc;
        got.busy = busy;
        got.dir  = dir;
        got.tick = sweep_tick;
        got.done = done;
        assert (got === e) else begin
          errors++;
          $error("FAIL %s[%0d]: got f=%0d inc=%0d busy=%0b dir=%0b tick=%0b done=%0b, exp f=%0d inc=%0d busy=%0b dir=%0b tick=%0b done=%0b",
                 tag, i, got.freq, got.inc, got.busy, got.dir, got.tick, got.done,
                 e.freq, e.inc, e.busy, e.dir, e.tick, e.done);
        end
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = DWELL_W'(d);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pat [6];
    pat = '{100, 110, 120, 130, 120, 110};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;

    // Reset defaults, during and after reset.
    push_idle(50, 0, 0);
    run_check(1, "reset_held");
    rst_n = 1'b1;
    push_idle(50, 0, 0);
    run_check(1, "reset_release");

    // Default config: step 1, dwell 1, advances by 1 per cycle.
    push_hold(50, 0, 1, 0);
    for (int f = 51; f < 60; f++) push_hold(f, 0, 1, 1);
    start = 1'b1;
    run_check(10, "default_sweep");
    push_idle(59, 0, 0);
    stop = 1'b1;
    run_check(1, "default_stop");

    // start and stop together in IDLE stays idle.
    push_idle(59, 0, 0);
    start = 1'b1; stop = 1'b1;
    run_check(1, "start_stop_idle");

    // Single sweep 100 -> 130, step 10, dwell 3.
    cfg_write(2'd0, 100);
    cfg_write(2'd1, 130);
    cfg_write(2'd2, 10);
    cfg_write(2'd3, 3);
    push_hold(100, 0, 3, 0);
    push_hold(110, 0, 3, 1);
    push_hold(120, 0, 3, 1);
    push_hold(130, 0, 3, 1);
    push_idle(130, 0, 1);
    push_idle(130, 0, 0);
    mode = 1'b0; start = 1'b1;
    run_check(14, "single_sweep");

    // Overshoot clamp on the last step.
    cfg_write(2'd1, 125);
    push_hold(100, 0, 3, 0);
    push_hold(110, 0, 3, 1);
    push_hold(120, 0, 3, 1);
    push_hold(125, 0, 3, 1);
    push_idle(125, 0, 1);
    push_idle(125, 0, 0);
    start = 1'b1;
    run_check(14, "overshoot");

    // Down sweep 125 -> 100, dir stays 0.
    cfg_write(2'd0, 125);
    cfg_write(2'd1, 100);
    push_hold(125, 0, 3, 0);
    push_hold(115, 0, 3, 1);
    push_hold(105, 0, 3, 1);
    push_hold(100, 0, 3, 1);
    push_idle(100, 0, 1);
    start = 1'b1;
    run_check(13, "down_sweep");

    // Triangle 100 <-> 130, dwell 2, 40 cycles with no done, then stop.
    cfg_write(2'd0, 100);
    cfg_write(2'd1, 130);
    cfg_write(2'd3, 2);
    for (int i = 0; i < 20; i++) begin
      push_hold(pat[i % 6], ((i % 6) >= 4) || ((i % 6) == 0 && i > 0), 2, i > 0);
    end
    mode = 1'b1; start = 1'b1;
    run_check(40, "triangle");
    push_idle(110, 0, 0);
    push_idle(110, 0, 0);
    stop = 1'b1;
    run_check(2, "triangle_stop");

    // Pause 5 cycles mid-dwell on 110, then stop during 120.
    cfg_write(2'd3, 3);
    push_hold(100, 0, 3, 0);
    push_hold(110, 0, 8, 1);
    push_hold(120, 0, 1, 1);
    push_idle(120, 0, 0);
    push_idle(120, 0, 0);
    mode = 1'b0; start = 1'b1;
    run_check(4, "pause_pre");
    pause = 1'b1;
    run_check(5, "pause_hold");
    pause = 1'b0;
    run_check(3, "pause_resume");
    stop = 1'b1;
    run_check(2, "pause_stop");

    // Snapshot: f_stop write mid-sweep does not disturb the running sweep.
    push_hold(100, 0, 3, 0);
    push_hold(110, 0, 3, 1);
    push_hold(120, 0, 3, 1);
    push_hold(130, 0, 3, 1);
    push_idle(130, 0, 1);
    push_idle(130, 0, 0);
    start = 1'b1;
    run_check(2, "snapshot_a");
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = DWELL_W'(30000);
    run_check(12, "snapshot_b");

    // Clamped config: f_start 0 -> 50, f_stop 30000 -> 25000, dwell 0 -> 1.
    cfg_write(2'd0, 0);
    cfg_write(2'd2, 10000);
    cfg_write(2'd3, 0);
    push_hold(50, 0, 1, 0);
    push_hold(10050, 0, 1, 1);
    push_hold(20050, 0, 1, 1);
    push_hold(25000, 0, 1, 1);
    push_idle(25000, 0, 1);
    push_idle(25000, 0, 0);
    start = 1'b1;
    run_check(6, "clamp_sweep");

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries left, exp 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
